seg_display_arbiter: RTL and testbench



---
 rtl/seg_arb_pkg.sv | 5 +
 rtl/rr_pick.sv | 34 +++
 rtl/seg_display_arbiter.sv | 81 ++++++++
 tb/tb_seg_display_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_arb_pkg;
  typedef enum logic {IDLE, SHOW} seg_arb_state_t;
  localparam int SEG_VAL_W = 32;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [REQ_W-1:0]   gnt_idx,
  output logic               any_valid
);

  int               idx;
  logic [REQ_W-1:0] sel;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = idx[REQ_W-1:0];
      if (!any_valid && req[sel]) begin
        any_valid = 1'b1;
        gnt[sel]  = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 8-digit seven-segment display with a minimum dwell
// per grant; val_out feeds seven_segment_controller.val_in.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int REQ_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [SEG_VAL_W*NUM_REQ-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [SEG_VAL_W-1:0]           val_out,
  output logic [REQ_W-1:0]               owner_out,
  output logic                           active_out
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  seg_arb_state_t       state;
  logic [31:0]          dwell_cnt;
  logic [REQ_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   gnt;
  logic [REQ_W-1:0]     gnt_idx;
  logic                 any_valid;
  logic                 arb_opp;
  logic [SEG_VAL_W-1:0] req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data[i] = req_data_in[i*SEG_VAL_W +: SEG_VAL_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_rr_pick (
    .req       (req_valid_in),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_valid (any_valid)
  );

  // The expiry cycle doubles as an arbitration slot so back-to-back grants leave no gap.
  assign arb_opp = (state == IDLE) || (dwell_cnt == DWELL_LAST);

  always_comb begin
    req_ready_out = '0;
    if (!rst_in) begin
      if (arb_opp) req_ready_out = gnt;
      else         req_ready_out[owner_out] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      dwell_cnt  <= '0;
      rr_ptr     <= '0;
      val_out    <= '0;
      owner_out  <= '0;
      active_out <= 1'b0;
    end else if (arb_opp) begin
      if (any_valid) begin
        val_out    <= req_data[gnt_idx];
        owner_out  <= gnt_idx;
        active_out <= 1'b1;
        dwell_cnt  <= '0;
        state      <= SHOW;
        rr_ptr     <= (gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_idx + REQ_W'(1);
      end else begin
        state      <= IDLE;
        active_out <= 1'b0;
      end
    end else begin
      // Owner may refresh its value mid-dwell without extending the dwell.
      dwell_cnt <= dwell_cnt + 32'd1;
      if (req_valid_in[owner_out]) val_out <= req_data[owner_out];
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=4, DWELL_CYCLES=8.
module tb_seg_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DWELL   = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [3:0]   req_valid_in = '0;
  logic [127:0] req_data_in  = '0;
  logic [3:0]   req_ready_out;
  logic [31:0]  val_out;
  logic [1:0]   owner_out;
  logic         active_out;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_arbiter #(.NUM_REQ(NUM_REQ), .DWELL_CYCLES(DWELL)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_ready_out (req_ready_out),
    .val_out       (val_out),
    .owner_out     (owner_out),
    .active_out    (active_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data_in[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    req_valid_in = 4'b1111;
    #1;
    n_checks++; if (req_ready_out !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready_out); end
    n_checks++; if (val_out !== 32'h0) begin n_fail++; $display("FAIL reset_val: got %h expected 0", val_out); end
    n_checks++; if (owner_out !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner_out); end
    n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active_out); end
    req_valid_in = '0;
    tick();
    rst_in = 1'b0;
    tick();
    n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b expected 0", active_out); end
  endtask

  task automatic test_single();
    set_data(1, 32'h0000_BEEF);
    req_valid_in = 4'b0010;
    #1;
    n_checks++; if (req_ready_out !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b expected 0010", req_ready_out); end
    tick();
    req_valid_in = '0;
    n_checks++; if (val_out !== 32'h0000_BEEF) begin n_fail++; $display("FAIL single_val: got %h expected 0000beef", val_out); end
    n_checks++; if (owner_out !== 2'd1) begin n_fail++; $display("FAIL single_owner: got %0d expected 1", owner_out); end
    n_checks++; if (active_out !== 1'b1) begin n_fail++; $display("FAIL single_active: got %b expected 1", active_out); end
    repeat (DWELL - 1) tick();
    n_checks++; if (active_out !== 1'b1) begin n_fail++; $display("FAIL single_last_dwell: got %b expected 1", active_out); end
    tick();
    n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL single_expired: got %b expected 0", active_out); end
    n_checks++; if (val_out !== 32'h0000_BEEF) begin n_fail++; $display("FAIL single_hold_val: got %h expected 0000beef", val_out); end
  endtask

  task automatic test_live_update();
    set_data(1, 32'h0000_1111);
    req_valid_in = 4'b0010;
    tick();
    req_valid_in = '0;
    n_checks++; if (val_out !== 32'h0000_1111) begin n_fail++; $display("FAIL live_grant_val: got %h expected 00001111", val_out); end
    repeat (3) tick();
    set_data(1, 32'h0000_1234);
    req_valid_in = 4'b0010;
    #1;
    n_checks++; if (req_ready_out !== 4'b0010) begin n_fail++; $display("FAIL live_ready: got %b expected 0010", req_ready_out); end
    tick();
    req_valid_in = '0;
    n_checks++; if (val_out !== 32'h0000_1234) begin n_fail++; $display("FAIL live_val: got %h expected 00001234", val_out); end
    repeat (3) tick();
    n_checks++; if (active_out !== 1'b1) begin n_fail++; $display("FAIL live_cnt7_active: got %b expected 1", active_out); end
    tick();
    n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL live_expiry: got %b expected 0", active_out); end
  endtask

  task automatic test_contention();
    do_reset();
    set_data(0, 32'hA000_0000);
    set_data(2, 32'hA000_0002);
    req_valid_in = 4'b0101;
    #1;
    n_checks++; if (req_ready_out !== 4'b0001) begin n_fail++; $display("FAIL cont_first_ready: got %b expected 0001", req_ready_out); end
    tick();
    n_checks++; if (owner_out !== 2'd0) begin n_fail++; $display("FAIL cont_owner0: got %0d expected 0", owner_out); end
    for (int k = 0; k < DWELL - 1; k++) begin
      n_checks++; if (req_ready_out !== 4'b0001) begin n_fail++; $display("FAIL cont_dwell_ready[%0d]: got %b expected 0001", k, req_ready_out); end
      tick();
    end
    n_checks++; if (req_ready_out !== 4'b0100) begin n_fail++; $display("FAIL cont_expiry_ready: got %b expected 0100", req_ready_out); end
    tick();
    n_checks++; if (owner_out !== 2'd2) begin n_fail++; $display("FAIL cont_owner2: got %0d expected 2", owner_out); end
    n_checks++; if (val_out !== 32'hA000_0002) begin n_fail++; $display("FAIL cont_val2: got %h expected a0000002", val_out); end
  endtask

  task automatic test_rr_wrap();
    set_data(3, 32'hB000_0003);
    req_valid_in = 4'b1000;
    repeat (DWELL - 1) tick();
    n_checks++; if (req_ready_out !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3: got %b expected 1000", req_ready_out); end
    tick();
    n_checks++; if (owner_out !== 2'd3) begin n_fail++; $display("FAIL wrap_owner3: got %0d expected 3", owner_out); end
    set_data(0, 32'hB000_0000);
    set_data(1, 32'hB000_0001);
    req_valid_in = 4'b0011;
    repeat (DWELL - 1) tick();
    n_checks++; if (req_ready_out !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b expected 0001", req_ready_out); end
    tick();
    n_checks++; if (owner_out !== 2'd0) begin n_fail++; $display("FAIL wrap_owner0: got %0d expected 0", owner_out); end
    repeat (DWELL) tick();
    n_checks++; if (owner_out !== 2'd1) begin n_fail++; $display("FAIL wrap_owner1: got %0d expected 1", owner_out); end
    n_checks++; if (val_out !== 32'hB000_0001) begin n_fail++; $display("FAIL wrap_val1: got %h expected b0000001", val_out); end
    req_valid_in = '0;
  endtask

  task automatic test_nonowner_blocked();
    do_reset();
    set_data(0, 32'hC000_0000);
    req_valid_in = 4'b0001;
    tick();
    set_data(3, 32'hDEAD_0003);
    req_valid_in = 4'b1000;
    for (int k = 0; k < DWELL - 1; k++) begin
      #1;
      n_checks++; if (req_ready_out[3] !== 1'b0) begin n_fail++; $display("FAIL blk_ready3[%0d]: got %b expected 0", k, req_ready_out[3]); end
      n_checks++; if (val_out !== 32'hC000_0000) begin n_fail++; $display("FAIL blk_val[%0d]: got %h expected c0000000", k, val_out); end
      tick();
    end
    n_checks++; if (req_ready_out !== 4'b1000) begin n_fail++; $display("FAIL blk_expiry_ready: got %b expected 1000", req_ready_out); end
    tick();
    req_valid_in = '0;
    n_checks++; if (val_out !== 32'hDEAD_0003) begin n_fail++; $display("FAIL blk_val3: got %h expected dead0003", val_out); end
    n_checks++; if (owner_out !== 2'd3) begin n_fail++; $display("FAIL blk_owner3: got %0d expected 3", owner_out); end
  endtask

  task automatic test_async_reset();
    repeat (4) tick();
    #2;
    rst_in = 1'b1;
    set_data(2, 32'hE000_0002);
    req_valid_in = 4'b0100;
    #1;
    n_checks++; if (val_out !== 32'h0) begin n_fail++; $display("FAIL arst_val: got %h expected 0", val_out); end
    n_checks++; if (owner_out !== 2'd0) begin n_fail++; $display("FAIL arst_owner: got %0d expected 0", owner_out); end
    n_checks++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL arst_active: got %b expected 0", active_out); end
    n_checks++; if (req_ready_out !== 4'b0000) begin n_fail++; $display("FAIL arst_ready: got %b expected 0000", req_ready_out); end
    #1;
    rst_in = 1'b0;
    #1;
    n_checks++; if (req_ready_out !== 4'b0100) begin n_fail++; $display("FAIL arst_rel_ready: got %b expected 0100", req_ready_out); end
    tick();
    req_valid_in = '0;
    n_checks++; if (owner_out !== 2'd2) begin n_fail++; $display("FAIL arst_owner2: got %0d expected 2", owner_out); end
    n_checks++; if (val_out !== 32'hE000_0002) begin n_fail++; $display("FAIL arst_val2: got %h expected e0000002", val_out); end
    n_checks++; if (active_out !== 1'b1) begin n_fail++; $display("FAIL arst_active1: got %b expected 1", active_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_live_update();
    test_contention();
    test_rr_wrap();
    test_nonowner_blocked();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
